// File: rtl/video_inst_sequencer.sv
// Instruction FIFO, decoder and command dispatcher for the DMA movers and stream router.
// Define VIDEO_SEQ_PERF_EN to add the stall_cycles / active_cycles performance counters.
module video_inst_sequencer #(
    parameter int ADDR_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int NR_FUN_UNITS = 2,
    parameter int DEST_WIDTH   = 3
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        inst_valid,
    input  logic [31:0]                 inst_data,
    output logic                        inst_ready,
    output logic [31:0]                 inst_peek,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [ADDR_WIDTH-1:0]       rd_src,
    output logic [12:0]                 rd_len,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [ADDR_WIDTH-1:0]       wr_dest,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [DEST_WIDTH-1:0]       routing_dest,
    output logic                        busy,
    output logic                        err_illegal,
    input  logic                        err_clear,
    output logic [31:0]                 retired_count
`ifdef VIDEO_SEQ_PERF_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 active_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    localparam logic [5:0] OP_NOP          = 6'd0;
    localparam logic [5:0] OP_LOAD_RD_FULL = 6'd2;
    localparam logic [5:0] OP_LOAD_WR_FULL = 6'd3;
    localparam logic [5:0] OP_LOAD_RD_LOW  = 6'd4;
    localparam logic [5:0] OP_LOAD_WR_LOW  = 6'd5;
    localparam logic [5:0] OP_MOV          = 6'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI_RD,
        S_LOAD_HI_WR,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]      mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fifo_full, fifo_empty, push, pop;
    logic [31:0]      head;

    logic [ADDR_WIDTH-1:0] base_rd_reg, base_rd_next;
    logic [ADDR_WIDTH-1:0] base_wr_reg, base_wr_next;
    logic [ADDR_WIDTH-1:0] rd_src_reg, rd_src_next;
    logic [ADDR_WIDTH-1:0] wr_dest_reg, wr_dest_next;
    logic [12:0]           rd_len_reg, rd_len_next;
    logic [DEST_WIDTH-1:0] routing_dest_reg, routing_dest_next;
    logic                  rd_valid_reg, rd_valid_next;
    logic                  wr_valid_reg, wr_valid_next;
    logic                  err_reg;
    logic [31:0]           retired_reg;
    logic                  retire, illegal_op;

    // Instruction FIFO; the head is read combinationally so IDLE can decode and pop in one cycle.
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);
    assign push       = inst_valid && !fifo_full;
    assign head       = mem_reg[rd_ptr_reg];

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= inst_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Decode of the head word
    logic [5:0]            opcode;
    logic [ADDR_WIDTH-1:0] src_off, dest_off;
    logic [12:0]           len;
    logic [NR_FUN_UNITS:0] cmd_hit;
    logic                  is_cmd;

    assign opcode   = head[5:0];
    assign src_off  = ADDR_WIDTH'({head[12:6], 6'b0});
    assign dest_off = ADDR_WIDTH'({head[19:13], 6'b0});
    assign len      = {head[26:20], 6'b0};

    // Entry 0 is MOV, entry k is functional unit k.
    genvar gi;
    generate
        for (gi = 0; gi <= NR_FUN_UNITS; gi++) begin : g_cmd_hit
            assign cmd_hit[gi] = (opcode == 6'(8 + gi));
        end
    endgenerate
    assign is_cmd = |cmd_hit;

    // Candidate base values for low-part and high-part loads.
    logic [ADDR_WIDTH-1:0] base_rd_lo, base_wr_lo, base_rd_hi, base_wr_hi;
    generate
        if (ADDR_WIDTH > 32) begin : g_wide
            assign base_rd_lo = {base_rd_reg[ADDR_WIDTH-1:32], head[31:6], 6'b0};
            assign base_wr_lo = {base_wr_reg[ADDR_WIDTH-1:32], head[31:6], 6'b0};
            assign base_rd_hi = {head[ADDR_WIDTH-33:0], base_rd_reg[31:0]};
            assign base_wr_hi = {head[ADDR_WIDTH-33:0], base_wr_reg[31:0]};
        end else begin : g_narrow
            assign base_rd_lo = {head[31:6], 6'b0};
            assign base_wr_lo = {head[31:6], 6'b0};
            assign base_rd_hi = base_rd_reg;
            assign base_wr_hi = base_wr_reg;
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        pop               = 1'b0;
        retire            = 1'b0;
        illegal_op        = 1'b0;
        base_rd_next      = base_rd_reg;
        base_wr_next      = base_wr_reg;
        rd_src_next       = rd_src_reg;
        wr_dest_next      = wr_dest_reg;
        rd_len_next       = rd_len_reg;
        routing_dest_next = routing_dest_reg;
        rd_valid_next     = rd_valid_reg;
        wr_valid_next     = wr_valid_reg;

        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_cmd) begin
                        if (len == 13'd0) begin
                            retire = 1'b1;
                        end else begin
                            rd_src_next       = base_rd_reg + src_off;
                            wr_dest_next      = base_wr_reg + dest_off;
                            rd_len_next       = len;
                            routing_dest_next = DEST_WIDTH'(opcode - OP_MOV);
                            rd_valid_next     = 1'b1;
                            wr_valid_next     = 1'b1;
                            state_next        = S_ISSUE;
                        end
                    end else begin
                        case (opcode)
                            OP_NOP: retire = 1'b1;
                            OP_LOAD_RD_LOW: begin
                                base_rd_next = base_rd_lo;
                                retire       = 1'b1;
                            end
                            OP_LOAD_WR_LOW: begin
                                base_wr_next = base_wr_lo;
                                retire       = 1'b1;
                            end
                            OP_LOAD_RD_FULL: begin
                                base_rd_next = base_rd_lo;
                                state_next   = S_LOAD_HI_RD;
                            end
                            OP_LOAD_WR_FULL: begin
                                base_wr_next = base_wr_lo;
                                state_next   = S_LOAD_HI_WR;
                            end
                            default: illegal_op = 1'b1;
                        endcase
                    end
                end
            end
            S_LOAD_HI_RD: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    base_rd_next = base_rd_hi;
                    retire       = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            S_LOAD_HI_WR: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    base_wr_next = base_wr_hi;
                    retire       = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            S_ISSUE: begin
                // Both handshakes complete independently; WAIT follows once both have landed.
                if (!rd_valid_reg && !wr_valid_reg) begin
                    state_next = S_WAIT;
                end
                if (rd_valid_reg && rd_ready) begin
                    rd_valid_next = 1'b0;
                end
                if (wr_valid_reg && wr_ready) begin
                    wr_valid_next = 1'b0;
                end
            end
            S_WAIT: begin
                if (rd_ready && wr_ready) begin
                    retire     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg        <= S_IDLE;
            base_rd_reg      <= '0;
            base_wr_reg      <= '0;
            rd_src_reg       <= '0;
            wr_dest_reg      <= '0;
            rd_len_reg       <= '0;
            routing_dest_reg <= '0;
            rd_valid_reg     <= 1'b0;
            wr_valid_reg     <= 1'b0;
            err_reg          <= 1'b0;
            retired_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            base_rd_reg      <= base_rd_next;
            base_wr_reg      <= base_wr_next;
            rd_src_reg       <= rd_src_next;
            wr_dest_reg      <= wr_dest_next;
            rd_len_reg       <= rd_len_next;
            routing_dest_reg <= routing_dest_next;
            rd_valid_reg     <= rd_valid_next;
            wr_valid_reg     <= wr_valid_next;
            if (err_clear) begin
                err_reg <= 1'b0;
            end else if (illegal_op) begin
                err_reg <= 1'b1;
            end
            if (retire) begin
                retired_reg <= retired_reg + 32'd1;
            end
        end
    end

    assign inst_ready    = !fifo_full;
    assign inst_peek     = fifo_empty ? 32'd0 : head;
    assign fifo_count    = count_reg;
    assign rd_src        = rd_src_reg;
    assign rd_len        = rd_len_reg;
    assign rd_valid      = rd_valid_reg;
    assign wr_dest       = wr_dest_reg;
    assign wr_valid      = wr_valid_reg;
    assign routing_dest  = routing_dest_reg;
    assign busy          = (state_reg != S_IDLE) || !fifo_empty;
    assign err_illegal   = err_reg;
    assign retired_count = retired_reg;

`ifdef VIDEO_SEQ_PERF_EN
    logic [31:0] stall_cycles_reg, active_cycles_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stall_cycles_reg  <= '0;
            active_cycles_reg <= '0;
        end else begin
            if (inst_valid && fifo_full && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (((state_reg == S_ISSUE) || (state_reg == S_WAIT)) &&
                (active_cycles_reg != 32'hFFFF_FFFF)) begin
                active_cycles_reg <= active_cycles_reg + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_cycles_reg;
    assign active_cycles = active_cycles_reg;
`endif

endmodule

// File: doc/video_inst_sequencer.md
Name: video_inst_sequencer

Overview:
- Parametrised instruction fetch/decode/dispatch engine for the video accelerator; successor to the fixed-depth, MOV-only decoder.
- Accepts 32-bit instructions over a valid/ready push port, buffers them in an internal FIFO, and maintains 64-bit read/write base addresses.
- Issues source/length commands to the DMA-to-local mover and destination commands to the local-to-DMA mover, and drives the stream router destination for up to NR_FUN_UNITS functional units.
- Adds backpressure, illegal-opcode detection, zero-length handling and a retire counter.

Parameters:
ADDR_WIDTH, 64, mover address width (32..64)
FIFO_DEPTH, 8, instruction FIFO entries (power of two, >=2)
NR_FUN_UNITS, 2, functional units addressable by opcode (1..7)
DEST_WIDTH, 3, router destination width; must satisfy 2^DEST_WIDTH > NR_FUN_UNITS

Ports:
aclk  in  1  clock
aresetn  in  1  reset
inst_valid  in  1  instruction push valid
inst_data  in  32  instruction word
inst_ready  out  1  FIFO can accept (= !full)
inst_peek  out  32  FIFO head word, 0 when empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
rd_src  out  ADDR_WIDTH  read-mover source address
rd_len  out  13  transfer length in bytes
rd_valid  out  1  read-mover command valid
rd_ready  in  1  read mover idle/accepting
wr_dest  out  ADDR_WIDTH  write-mover destination address
wr_valid  out  1  write-mover command valid
wr_ready  in  1  write mover idle/accepting
routing_dest  out  DEST_WIDTH  router destination for the current command
busy  out  1  state != IDLE or FIFO non-empty
err_illegal  out  1  sticky illegal-opcode flag
err_clear  in  1  clears err_illegal
retired_count  out  32  retired instructions, wraps at 2^32

Behaviour:
- Interface: one clock, aclk; reset aresetn is synchronous and active-low. Reset clears the FIFO, both base addresses, the state machine (to IDLE), all valids, routing_dest, err_illegal and retired_count. Every output is 0 after reset except inst_ready, which is 1. Reset during a transfer abandons it; no completion wait.
- Instruction fields: opcode[5:0]; src = {[12:6],6'b0}; dest = {[19:13],6'b0}; len = {[26:20],6'b0}; attrib[31:27] is ignored.
- Opcodes: NOP=0, LOAD_RD_FULL=2, LOAD_WR_FULL=3, LOAD_RD_LOW=4, LOAD_WR_LOW=5, MOV=8, FUN k = 8+k for k = 1..NR_FUN_UNITS. Every other opcode is illegal.
- FIFO push: on inst_valid && inst_ready. When full, inst_ready=0 and no word is written, even if a pop happens in the same cycle. Simultaneous push and pop when not full leaves fifo_count unchanged. Push/pop-to-count latency is 1 cycle.
- FSM states: IDLE, LOAD_HI_RD, LOAD_HI_WR, ISSUE, WAIT.
- IDLE with FIFO non-empty: the head word is popped combinationally in the same cycle it is decoded.
  - NOP: retire.
  - LOAD_*_LOW: base[31:6] <= word[31:6]; base[5:0] stays 0; retire.
  - LOAD_*_FULL: same low-part load, then go to LOAD_HI_*; the instruction retires when its second word is consumed.
  - MOV/FUN: rd_src <= base_rd+src and wr_dest <= base_wr+dest, both truncated to ADDR_WIDTH and wrapping; rd_len <= len; routing_dest <= opcode-8; raise rd_valid and wr_valid; go to ISSUE.
  - MOV/FUN with len==0: no command issued, retire, stay in IDLE.
  - Illegal opcode: pop, set err_illegal, do not retire.
- LOAD_HI_*: waits while the FIFO is empty. Pops the next word into base[63:32]; with ADDR_WIDTH<=32 the word is popped and discarded. Retires, then IDLE.
- ISSUE: each valid stays high until its own valid&&ready, then drops. The two handshakes are independent and may complete in different cycles. Go to WAIT the cycle after both valids are low.
- WAIT: stay at least 1 cycle. Return to IDLE and retire when rd_ready && wr_ready. routing_dest is held until the next MOV/FUN.
- Retire: retired_count increments once, 1 cycle after the pop or completion.
- err_illegal: err_clear has priority over a same-cycle new error.

Optional Feature:
- Macro VIDEO_SEQ_PERF_EN.
- When defined: adds outputs stall_cycles[31:0] and active_cycles[31:0]. stall_cycles counts cycles with inst_valid && !inst_ready. active_cycles counts cycles in ISSUE or WAIT. Both are cleared by reset and saturate at 2^32-1.
- When undefined: neither port nor the counter logic exists.

Test Plan:
- Push LOAD_RD_LOW (word 0x00001004), then MOV with src field 2 and len field 1; rd_ready=wr_ready=1 -> rd_src=0x1080, rd_len=64, routing_dest=0, retired_count=2.
- LOAD_WR_FULL with low 0x40, then high word 0xDEADBEEF -> base_wr=0xDEADBEEF_00000040, retired_count=1 only after the second word is popped.
- Fill the FIFO with 8 words while the FSM is stalled in WAIT -> inst_ready=0, a 9th push is dropped, fifo_count=8; the push after one pop is accepted.
- FUN2 (opcode 0xA) with rd_ready accepting 3 cycles before wr_ready -> valids drop independently, routing_dest=2, IDLE only after both readies return high.
- Opcode 0x3F, then MOV with len=0 -> err_illegal=1, no valid pulses, retired_count=1; err_clear asserted with a new illegal opcode in the same cycle -> err_illegal=0.
- Assert aresetn=0 for one cycle mid-WAIT -> all outputs 0, inst_ready=1, FIFO empty, state IDLE.
